param_clock: RTL and testbench

Parametrised 24-hour time-of-day counter with a programmable tick prescaler and 12/24-hour display selection. It supports four modes: run, set, hold and clear. In set mode, pushbutton keys advance each field once per press with no carry into other fields. It feeds the seven-segment/display decode stage with packed {hour,min,sec} plus a PM flag.

---
 rtl/param_clock_pkg.sv | 22 ++
 rtl/param_clock_if.sv | 41 ++++
 rtl/param_clock_mod_counter.sv | 27 ++
 rtl/param_clock.sv | 138 +++++++++++++
 tb/tb_param_clock.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/param_clock_pkg.sv
// Shared definitions for the time-of-day counter.
//   mode_t       : run / set / hold / clear encodings of the mode input
//   *_MAX        : terminal count of each time field
//   *_W          : width of each field in the packed clock output
package clock_pkg;

    typedef enum logic [1:0] {
        MODE_RUN   = 2'b00,
        MODE_SET   = 2'b01,
        MODE_HOLD  = 2'b10,
        MODE_CLEAR = 2'b11
    } mode_t;

    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int HOUR_W = 6;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;

endpackage

// File: rtl/param_clock_if.sv
// Control/display bundle of the time-of-day counter.
//   mode, h12, hourkey/minkey/seckey : controls driven by the master
//   clock {hour,min,sec}, pm, tick   : display outputs driven by the slave
//   alarm_h/alarm_m/alarm_ack/alarm  : only present with PARAM_CLOCK_ALARM_EN
interface param_clock_if;
    import clock_pkg::*;

    mode_t                          mode;
    logic                           h12;
    logic                           hourkey;
    logic                           minkey;
    logic                           seckey;
    logic [HOUR_W+MIN_W+SEC_W-1:0]  clock;
    logic                           pm;
    logic                           tick;
`ifdef PARAM_CLOCK_ALARM_EN
    logic [4:0]                     alarm_h;
    logic [5:0]                     alarm_m;
    logic                           alarm_ack;
    logic                           alarm;
`endif

    modport master (
        output mode, h12, hourkey, minkey, seckey,
`ifdef PARAM_CLOCK_ALARM_EN
        output alarm_h, alarm_m, alarm_ack,
        input  alarm,
`endif
        input  clock, pm, tick
    );

    modport slave (
        input  mode, h12, hourkey, minkey, seckey,
`ifdef PARAM_CLOCK_ALARM_EN
        input  alarm_h, alarm_m, alarm_ack,
        output alarm,
`endif
        output clock, pm, tick
    );

endinterface

// File: rtl/param_clock_mod_counter.sv
// Modulo-(MAX+1) field counter.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0 (wins over inc)
//   inc      : advance by one, wrapping MAX -> 0
//   value    : current count
//   wrap     : combinational, inc && value == MAX (carry out)
module mod_counter #(
    parameter int MAX = 59,
    parameter int W   = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] value,
    output logic         wrap
);

    assign wrap = inc && (value == W'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       value <= '0;
        else if (clr)  value <= '0;
        else if (inc)  value <= wrap ? '0 : value + W'(1);
    end

endmodule

// File: rtl/param_clock.sv
// 24-hour time-of-day counter with tick prescaler and 12/24-hour display.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : param_clock_if.slave (mode, h12, keys in; clock, pm, tick out)
// Parameters: TICK_DIV clk cycles per second, CNT_W prescaler width.
// Optional: PARAM_CLOCK_ALARM_EN adds the alarm comparator and ring timer.
module param_clock
    import clock_pkg::*;
#(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic          clk,
    input  logic          rst,
    param_clock_if.slave  bus
);

    logic [CNT_W-1:0]  pre_cnt;
    logic              tick_en;
    logic              tick_q;
    logic [2:0]        key_q;     // {hour,min,sec} previous-cycle key levels
    logic [2:0]        key_rise;
    logic              clr, sec_inc, min_inc, hour_inc;
    logic              sec_wrap, min_wrap;
    logic [SEC_W-1:0]  sec_v;
    logic [MIN_W-1:0]  min_v;
    logic [HOUR_W-1:0] hour_v;
    logic [HOUR_W-1:0] hour_disp;

    // tick_en marks the last prescaler count; the time advances on that edge
    // and the registered tick pulse appears together with the new time.
    assign tick_en = (pre_cnt == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
            tick_q  <= 1'b0;
            key_q   <= '0;
        end else begin
            pre_cnt <= tick_en ? '0 : pre_cnt + CNT_W'(1);
            tick_q  <= tick_en;
            key_q   <= {bus.hourkey, bus.minkey, bus.seckey};
        end
    end

    // Edge registers run in every mode so a key held while entering set
    // mode needs a fresh press.
    assign key_rise = {bus.hourkey, bus.minkey, bus.seckey} & ~key_q;

    // Run chains carries through the wrap outputs; set drives each field
    // independently so a wrap never carries.
    always_comb begin
        clr      = 1'b0;
        sec_inc  = 1'b0;
        min_inc  = 1'b0;
        hour_inc = 1'b0;
        case (bus.mode)
            MODE_RUN: begin
                sec_inc  = tick_en;
                min_inc  = sec_wrap;
                hour_inc = min_wrap;
            end
            MODE_SET: begin
                sec_inc  = key_rise[0];
                min_inc  = key_rise[1];
                hour_inc = key_rise[2];
            end
            MODE_CLEAR: clr = 1'b1;
            default: ;
        endcase
    end

    mod_counter #(.MAX(SEC_MAX), .W(SEC_W)) u_sec (
        .clk(clk), .rst(rst), .clr(clr), .inc(sec_inc), .value(sec_v), .wrap(sec_wrap)
    );

    mod_counter #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
        .clk(clk), .rst(rst), .clr(clr), .inc(min_inc), .value(min_v), .wrap(min_wrap)
    );

`ifdef PARAM_CLOCK_ALARM_EN
    logic hour_wrap;
    mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
        .clk(clk), .rst(rst), .clr(clr), .inc(hour_inc), .value(hour_v), .wrap(hour_wrap)
    );
`else
    mod_counter #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
        .clk(clk), .rst(rst), .clr(clr), .inc(hour_inc), .value(hour_v), .wrap()
    );
`endif

    always_comb begin
        hour_disp = hour_v;
        if (bus.h12) begin
            if (hour_v == '0)                   hour_disp = HOUR_W'(12);
            else if (hour_v > HOUR_W'(12))      hour_disp = hour_v - HOUR_W'(12);
        end
    end

    assign bus.clock = {hour_disp, min_v, sec_v};
    assign bus.pm    = (hour_v >= HOUR_W'(12));
    assign bus.tick  = tick_q;

`ifdef PARAM_CLOCK_ALARM_EN
    logic [5:0]        ring_cnt;
    logic              alarm_q;
    logic              alarm_set;
    logic [MIN_W-1:0]  min_n;
    logic [HOUR_W-1:0] hour_n;

    // Look at the values the time registers are about to take so the alarm
    // rises on the same edge the time becomes hh:mm:00. Only a run-mode
    // second wrap can land on :00 with minutes advancing.
    always_comb begin
        min_n     = min_wrap ? '0 : min_v + MIN_W'(1);
        hour_n    = hour_wrap ? '0 : (min_wrap ? hour_v + HOUR_W'(1) : hour_v);
        alarm_set = (bus.mode == MODE_RUN) && sec_wrap &&
                    (min_n == bus.alarm_m) && (hour_n == {1'b0, bus.alarm_h});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_q  <= 1'b0;
            ring_cnt <= '0;
        end else if (bus.alarm_ack || bus.mode == MODE_CLEAR) begin
            alarm_q  <= 1'b0;
        end else if (alarm_set) begin
            alarm_q  <= 1'b1;
            ring_cnt <= '0;
        end else if (alarm_q && tick_en) begin
            if (ring_cnt == 6'd59) alarm_q  <= 1'b0;
            else                   ring_cnt <= ring_cnt + 6'd1;
        end
    end

    assign bus.alarm = alarm_q;
`endif

endmodule

// File: tb/tb_param_clock.sv
module tb_param_clock;
    import clock_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    param_clock_if ifc ();

    param_clock #(.TICK_DIV(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] hms(input int h, input int m, input int s);
        return {6'(h), 6'(m), 6'(s)};
    endfunction

    // {hour,min,sec} key press: high for one cycle, low for one cycle.
    task automatic press(input logic [2:0] k);
        {ifc.hourkey, ifc.minkey, ifc.seckey} = k;
        @(negedge clk);
        {ifc.hourkey, ifc.minkey, ifc.seckey} = 3'b000;
        @(negedge clk);
    endtask

    // Clear, then key the fields up from zero; leaves the block in set mode.
    task automatic set_time(input int h, input int m, input int s);
        ifc.mode = MODE_CLEAR;
        @(negedge clk);
        ifc.mode = MODE_SET;
        for (int i = 0; i < h; i++) press(3'b100);
        for (int i = 0; i < m; i++) press(3'b010);
        for (int i = 0; i < s; i++) press(3'b001);
    endtask

    // Advance to the first cycle that shows a tick pulse, bounded.
    task automatic wait_tick(input string name);
        bit seen = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (ifc.tick) begin
                seen = 1;
                break;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no tick within 16 cycles", name);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (ifc.clock !== 18'd0 || ifc.pm !== 1'b0 || ifc.tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: clock=%h pm=%b tick=%b, want 0/0/0", ifc.clock, ifc.pm, ifc.tick);
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (ifc.clock !== hms(0, 0, 2)) begin
            errors++;
            $display("FAIL pre_reset_run: clock=%h want %h", ifc.clock, hms(0, 0, 2));
        end
        // Assert reset away from any clock edge; outputs must clear at once.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ifc.clock !== 18'd0 || ifc.tick !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: clock=%h tick=%b want 0/0", ifc.clock, ifc.tick);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (ifc.tick !== ((k % 4) == 0)) begin
                errors++;
                $display("FAIL tick_cycle%0d: tick=%b want %b", k, ifc.tick, (k % 4) == 0);
            end
        end
        checks++;
        if (ifc.clock !== hms(0, 0, 3)) begin
            errors++;
            $display("FAIL sec_after_12: clock=%h want %h", ifc.clock, hms(0, 0, 3));
        end
    endtask

    task automatic test_rollover();
        set_time(23, 59, 58);
        checks++;
        if (ifc.clock !== hms(23, 59, 58)) begin
            errors++;
            $display("FAIL preload: clock=%h want %h", ifc.clock, hms(23, 59, 58));
        end
        ifc.mode = MODE_RUN;
        wait_tick("roll_tick1");
        checks++;
        if (ifc.clock !== hms(23, 59, 59) || ifc.pm !== 1'b1) begin
            errors++;
            $display("FAIL roll_235959: clock=%h pm=%b want %h/1", ifc.clock, ifc.pm, hms(23, 59, 59));
        end
        wait_tick("roll_tick2");
        checks++;
        if (ifc.clock !== 18'd0 || ifc.pm !== 1'b0) begin
            errors++;
            $display("FAIL roll_midnight: clock=%h pm=%b want 0/0", ifc.clock, ifc.pm);
        end
    endtask

    task automatic test_set_keys();
        set_time(10, 59, 59);
        press(3'b001);
        checks++;
        if (ifc.clock !== hms(10, 59, 0)) begin
            errors++;
            $display("FAIL sec_wrap_nocarry: clock=%h want %h", ifc.clock, hms(10, 59, 0));
        end
        press(3'b010);
        checks++;
        if (ifc.clock !== hms(10, 0, 0)) begin
            errors++;
            $display("FAIL min_wrap_nocarry: clock=%h want %h", ifc.clock, hms(10, 0, 0));
        end
        ifc.hourkey = 1'b1;
        repeat (10) @(negedge clk);
        ifc.hourkey = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.clock !== hms(11, 0, 0)) begin
            errors++;
            $display("FAIL hour_held: clock=%h want %h", ifc.clock, hms(11, 0, 0));
        end
        press(3'b111);
        checks++;
        if (ifc.clock !== hms(12, 1, 1)) begin
            errors++;
            $display("FAIL simultaneous_keys: clock=%h want %h", ifc.clock, hms(12, 1, 1));
        end
        // Key already high when set mode is entered must not count.
        ifc.mode   = MODE_HOLD;
        ifc.seckey = 1'b1;
        repeat (3) @(negedge clk);
        ifc.mode = MODE_SET;
        repeat (3) @(negedge clk);
        checks++;
        if (ifc.clock !== hms(12, 1, 1)) begin
            errors++;
            $display("FAIL held_into_set: clock=%h want %h", ifc.clock, hms(12, 1, 1));
        end
        ifc.seckey = 1'b0;
        @(negedge clk);
        press(3'b001);
        checks++;
        if (ifc.clock !== hms(12, 1, 2)) begin
            errors++;
            $display("FAIL repress_after_held: clock=%h want %h", ifc.clock, hms(12, 1, 2));
        end
    endtask

    task automatic test_h12();
        int hrs  [4] = '{0, 12, 13, 23};
        int disp [4] = '{12, 12, 1, 11};
        logic pms[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        ifc.h12 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_time(hrs[i], 0, 0);
            checks++;
            if (ifc.clock[17:12] !== 6'(disp[i]) || ifc.pm !== pms[i]) begin
                errors++;
                $display("FAIL h12_hour%0d: field=%0d pm=%b want %0d/%b",
                         hrs[i], ifc.clock[17:12], ifc.pm, disp[i], pms[i]);
            end
        end
        press(3'b100);   // 23 -> 0, no carry anywhere
        checks++;
        if (ifc.clock !== hms(12, 0, 0) || ifc.pm !== 1'b0) begin
            errors++;
            $display("FAIL hour_wrap_h12: clock=%h pm=%b want %h/0", ifc.clock, ifc.pm, hms(12, 0, 0));
        end
        ifc.h12 = 1'b0;
        @(negedge clk);
        checks++;
        if (ifc.clock !== 18'd0) begin
            errors++;
            $display("FAIL h24_midnight: clock=%h want 0", ifc.clock);
        end
    endtask

    task automatic test_hold_clear();
        set_time(5, 6, 7);
        ifc.mode = MODE_HOLD;
        ifc.seckey = 1'b1;
        repeat (20) @(negedge clk);
        ifc.seckey = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (ifc.clock !== hms(5, 6, 7)) begin
            errors++;
            $display("FAIL hold_frozen: clock=%h want %h", ifc.clock, hms(5, 6, 7));
        end
        ifc.mode = MODE_CLEAR;
        @(negedge clk);
        checks++;
        if (ifc.clock !== 18'd0) begin
            errors++;
            $display("FAIL clear_mode: clock=%h want 0", ifc.clock);
        end
        ifc.mode = MODE_RUN;
        wait_tick("resume_tick");
        checks++;
        if (ifc.clock !== hms(0, 0, 1)) begin
            errors++;
            $display("FAIL run_resume: clock=%h want %h", ifc.clock, hms(0, 0, 1));
        end
    endtask

`ifdef PARAM_CLOCK_ALARM_EN
    task automatic test_alarm();
        ifc.alarm_h = 5'd0;
        ifc.alarm_m = 6'd1;
        set_time(0, 0, 58);
        ifc.mode = MODE_RUN;
        wait_tick("alarm_tick1");
        checks++;
        if (ifc.alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_early: alarm=%b want 0", ifc.alarm);
        end
        wait_tick("alarm_tick2");
        checks++;
        if (ifc.alarm !== 1'b1 || ifc.clock !== hms(0, 1, 0)) begin
            errors++;
            $display("FAIL alarm_set: alarm=%b clock=%h want 1/%h", ifc.alarm, ifc.clock, hms(0, 1, 0));
        end
        ifc.alarm_ack = 1'b1;
        @(negedge clk);
        ifc.alarm_ack = 1'b0;
        checks++;
        if (ifc.alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_ack: alarm=%b want 0", ifc.alarm);
        end
        set_time(0, 0, 58);
        ifc.mode = MODE_RUN;
        wait_tick("alarm2_tick1");
        wait_tick("alarm2_tick2");
        for (int i = 0; i < 59; i++) wait_tick("ring_tick");
        checks++;
        if (ifc.alarm !== 1'b1) begin
            errors++;
            $display("FAIL alarm_59_ticks: alarm=%b want 1", ifc.alarm);
        end
        wait_tick("ring_tick60");
        checks++;
        if (ifc.alarm !== 1'b0) begin
            errors++;
            $display("FAIL alarm_timeout: alarm=%b want 0", ifc.alarm);
        end
    endtask
`endif

    initial begin
        ifc.mode    = MODE_RUN;
        ifc.h12     = 1'b0;
        ifc.hourkey = 1'b0;
        ifc.minkey  = 1'b0;
        ifc.seckey  = 1'b0;
`ifdef PARAM_CLOCK_ALARM_EN
        ifc.alarm_h   = 5'd0;
        ifc.alarm_m   = 6'd0;
        ifc.alarm_ack = 1'b0;
`endif
        test_reset();
        test_rollover();
        test_set_keys();
        test_h12();
        test_hold_clear();
`ifdef PARAM_CLOCK_ALARM_EN
        test_alarm();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
